hex_display_bank: RTL and testbench

Parametrised multi-digit driver for the board's active-low seven-segment displays. It replaces per-digit combinational decoders and fixed button patterns with one registered block that:
- captures a packed hex value and a display mode on a load strobe;
- decodes every digit, with optional leading-zero blanking, a dash pattern and a blank mode;
- blinks selected digits from an internal prescaler.

It sits between the arithmetic datapath and the HEX output pins.

---
 rtl/hex_display_bank.sv | 85 ++++++++
 tb/tb_hex_display_bank.sv | 120 ++++++++++++
 2 files changed

// File: rtl/hex_display_bank.sv
// hex_display_bank: registered multi-digit active-low seven-segment driver.
// Ports: clk, rst (sync, active high); load captures value/mode/dash_mask/blink_mask;
// load_ack pulses the cycle after a capture; seg carries 7 active-low bits per digit (g..a).
// Define HEXDISP_BLINK_EN to build the blink prescaler and apply blink_mask.
module hex_display_bank #(
  parameter int DIGITS = 6,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [1:0]            mode,
  input  logic [DIGITS-1:0]     dash_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic                  load_ack,
  output logic [7*DIGITS-1:0]   seg
);
  localparam logic [111:0] GLYPHS = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                     7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  logic [4*DIGITS-1:0] value_q;
  logic [1:0]          mode_q;
  logic [DIGITS-1:0]   dash_q;
  logic [DIGITS-1:0]   blink_now;
  logic                load_ack_q;
  logic [7*DIGITS-1:0] seg_q, seg_d;
`ifdef HEXDISP_BLINK_EN
  localparam int CW = $clog2(BLINK_DIV);
  logic [CW-1:0]     cnt_q;
  logic              phase_q;
  logic [DIGITS-1:0] blink_q;
  logic              wrap;
  assign wrap = cnt_q == CW'(BLINK_DIV - 1);
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      blink_q <= '0;
    end else begin
      cnt_q   <= wrap ? '0 : cnt_q + 1'b1;
      phase_q <= phase_q ^ wrap;
      if (load) blink_q <= blink_mask;
    end
  assign blink_now = phase_q ? blink_q : '0;
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask ^ (BLINK_DIV < 2);
  assign blink_now = '0;
`endif
  // lead stays set while every digit from the top down to i is zero; digit 0 never counts as leading
  always_comb begin
    logic       lead;
    logic [3:0] nib;
    logic [6:0] hex;
    lead  = 1'b1;
    nib   = '0;
    hex   = '0;
    seg_d = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib  = value_q[4*i +: 4];
      hex  = GLYPHS[7*nib +: 7];
      lead = lead && nib == 4'd0 && i != 0;
      seg_d[7*i +: 7] = (blink_now[i] || mode_q == 2'b11 || (mode_q == 2'b01 && lead)) ? 7'h7F :
                        (mode_q == 2'b10 && dash_q[i]) ? 7'h3F : hex;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      value_q    <= '0;
      mode_q     <= 2'b11;
      dash_q     <= '0;
      load_ack_q <= 1'b0;
      seg_q      <= '1;
    end else begin
      if (load) begin
        value_q <= value;
        mode_q  <= mode;
        dash_q  <= dash_mask;
      end
      load_ack_q <= load;
      seg_q      <= seg_d;
    end
  assign load_ack = load_ack_q;
  assign seg      = seg_q;
endmodule

// File: tb/tb_hex_display_bank.sv
// tb_hex_display_bank: randomized and directed checks of hex_display_bank against a behavioural model
module tb_hex_display_bank;
  localparam int DIGITS = 6;
  localparam int BD = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [23:0] value = '0;
  logic [1:0]  mode = '0;
  logic [5:0]  dash_mask = '0;
  logic [5:0]  blink_mask = '0;
  logic        load_ack;
  logic [41:0] seg;
  int n_tests = 0;
  int n_fail = 0;
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [23:0] m_val;
  logic [1:0]  m_mode;
  logic [5:0]  m_dash, m_blink;
  int          k;
  logic [41:0] exp_seg;
  logic        exp_ack;

  hex_display_bank #(.DIGITS(DIGITS), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .mode(mode),
    .dash_mask(dash_mask), .blink_mask(blink_mask), .load_ack(load_ack), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [41:0] ref_seg(input logic [23:0] v, input logic [1:0] m,
                                          input logic [5:0] d, input logic [5:0] bm);
    logic [6:0] g;
    ref_seg = '1;
    for (int i = 0; i < DIGITS; i++) begin
      g = glyph[(v >> (4*i)) & 24'hF];
      if (m == 2'd1 && i > 0 && (v >> (4*i)) == 0) g = 7'h7F;
      if (m == 2'd2 && d[i]) g = 7'h3F;
      if (m == 2'd3) g = 7'h7F;
      if (bm[i]) g = 7'h7F;
      ref_seg[7*i +: 7] = g;
    end
  endfunction

  task automatic cyc(input logic r, input logic l, input logic [23:0] v, input logic [1:0] m,
                     input logic [5:0] d, input logic [5:0] b);
    logic [5:0] bm;
    @(negedge clk);
    rst = r; load = l; value = v; mode = m; dash_mask = d; blink_mask = b;
    @(posedge clk);
    if (r) begin
      exp_seg = '1; exp_ack = 1'b0;
      m_val = '0; m_mode = 2'd3; m_dash = '0; m_blink = '0; k = 0;
    end else begin
      k++;
      bm = '0;
`ifdef HEXDISP_BLINK_EN
      if (((k - 1) / BD) % 2 == 1) bm = m_blink;
`endif
      exp_seg = ref_seg(m_val, m_mode, m_dash, bm);
      exp_ack = l;
      if (l) begin
        m_val = v; m_mode = m; m_dash = d; m_blink = b;
      end
    end
    #1;
    check("seg", {22'd0, seg}, {22'd0, exp_seg});
    check("load_ack", {63'd0, load_ack}, {63'd0, exp_ack});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 24'($urandom), 2'($urandom), 6'($urandom), 6'($urandom));
  endtask

  initial begin
    cyc(1'b1, 1'b1, 24'($urandom), 2'($urandom), 6'($urandom), 6'($urandom));
    cyc(1'b1, 1'b1, 24'($urandom), 2'($urandom), 6'($urandom), 6'($urandom));
    check("reset_seg", {22'd0, seg}, {22'd0, {42{1'b1}}});
    idle(1);
    check("post_reset_ack", {63'd0, load_ack}, 64'd0);
    cyc(1'b0, 1'b1, 24'h1A3F09, 2'b00, 6'd0, 6'd0);
    check("hex_ack", {63'd0, load_ack}, 64'd1);
    idle(1);
    check("hex", {22'd0, seg}, {22'd0, 7'h79, 7'h08, 7'h30, 7'h0E, 7'h40, 7'h10});
    check("hex_ack_low", {63'd0, load_ack}, 64'd0);
    cyc(1'b0, 1'b1, 24'h000420, 2'b01, 6'd0, 6'd0);
    idle(1);
    check("lzb", {22'd0, seg}, {22'd0, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24, 7'h40});
    cyc(1'b0, 1'b1, 24'h000000, 2'b01, 6'd0, 6'd0);
    idle(1);
    check("lzb_zero", {22'd0, seg}, {22'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    cyc(1'b0, 1'b1, 24'h123456, 2'b10, 6'b110011, 6'd0);
    idle(1);
    check("dash", {22'd0, seg}, {22'd0, 7'h3F, 7'h3F, 7'h30, 7'h19, 7'h3F, 7'h3F});
    cyc(1'b0, 1'b1, 24'h123456, 2'b11, 6'b110011, 6'd0);
    idle(1);
    check("blank", {22'd0, seg}, {22'd0, {42{1'b1}}});
    cyc(1'b0, 1'b1, 24'h1A3F09, 2'b00, 6'd0, 6'b000001);
    idle(20);
    cyc(1'b0, 1'b1, 24'h654321, 2'b00, 6'd0, 6'b000001);
    cyc(1'b0, 1'b1, 24'h000042, 2'b01, 6'd0, 6'b100001);
    idle(10);
    cyc(1'b1, 1'b0, 24'd0, 2'd0, 6'd0, 6'd0);
    idle(12);
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, 24'($urandom), 2'($urandom),
          6'($urandom), 6'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
